// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer.
// Holds opcode constants, the FSM state type and the nibble width.
package nibble_serial_alu_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // op[1] set means the adder path is in use (ADD/SUB/SLT).
    function automatic logic is_arith(input logic [2:0] op);
        return op[1];
    endfunction

    // op[1:0] == 11 selects set-on-less-than.
    function automatic logic is_slt(input logic [2:0] op);
        return op[1] & op[0];
    endfunction

endpackage

// File: rtl/nibble_serial_alu_ctrl_mux.sv
// Nibble selector: returns nibble sel_i of a WIDTH-bit word.
// Ports: data_i word, sel_i nibble index, nib_o selected nibble.
module nibble_serial_alu_ctrl_mux
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / NIBBLE_W,
    parameter int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic [WIDTH-1:0]    data_i,
    input  logic [KW-1:0]       sel_i,
    output logic [NIBBLE_W-1:0] nib_o
);

    assign nib_o = data_i[NIBBLE_W*int'(sel_i) +: NIBBLE_W];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequencer driving a 4-bit ALU slice one nibble per cycle, low first.
// Ports: start/busy/done handshake, operands a/b/op, result+flags, slice bus.
module nibble_serial_alu_ctrl
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / NIBBLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [2:0]          op,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                cout,
    output logic                overflow,
    output logic                zero,
    output logic [NIBBLE_W-1:0] alu_a,
    output logic [NIBBLE_W-1:0] alu_b,
    output logic [2:0]          alu_op,
    output logic                alu_cin,
    input  logic [NIBBLE_W-1:0] alu_result,
    input  logic                alu_cout,
    input  logic                alu_set,
    input  logic                alu_overflow
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                result_d[NIBBLE_W*int'(k_q) +: NIBBLE_W] = alu_result;
                carry_d = alu_cout;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                    k_d     = '0;
                    // Logic ops never report carry or overflow.
                    cout_d  = is_arith(op_q) & alu_cout;
                    ovf_d   = is_arith(op_q) & alu_overflow;
                    // Sign of the adder corrected by overflow gives the
                    // true signed comparison.
                    if (is_slt(op_q)) begin
                        result_d = {{(WIDTH-1){1'b0}},
                                    alu_set ^ alu_overflow};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    nibble_serial_alu_ctrl_mux #(
        .WIDTH   (WIDTH),
        .NIBBLES (NIBBLES),
        .KW      (KW)
    ) u_mux_a (
        .data_i (a_q),
        .sel_i  (k_q),
        .nib_o  (alu_a)
    );

    nibble_serial_alu_ctrl_mux #(
        .WIDTH   (WIDTH),
        .NIBBLES (NIBBLES),
        .KW      (KW)
    ) u_mux_b (
        .data_i (b_q),
        .sel_i  (k_q),
        .nib_o  (alu_b)
    );

    // Nibble 0 takes binv as carry-in so SUB/SLT form two's complement.
    assign alu_cin  = (k_q == '0) ? op_q[2] : carry_q;
    assign alu_op   = op_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = (result_q == '0);

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench for nibble_serial_alu_ctrl with a 4-bit slice model.
// Directed vectors plus a per-cycle compare against a 16-bit reference.
module tb_nibble_serial_alu_ctrl;
    import nibble_serial_alu_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        zero;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic [3:0]  alu_result;
    logic        alu_cout;
    logic        alu_set;
    logic        alu_overflow;

    int checks = 0;
    int errors = 0;

    nibble_serial_alu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .a            (a),
        .b            (b),
        .op           (op),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .cout         (cout),
        .overflow     (overflow),
        .zero         (zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_cin      (alu_cin),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_set      (alu_set),
        .alu_overflow (alu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four-bit ALU slice: AND/OR/ADD with optional b inversion.
    logic [3:0] s_bb;
    logic [4:0] s_sum;
    always_comb begin
        s_bb  = alu_op[2] ? ~alu_b : alu_b;
        s_sum = {1'b0, alu_a} + {1'b0, s_bb} + 5'(alu_cin);
        case (alu_op[1:0])
            2'b00:   alu_result = alu_a & s_bb;
            2'b01:   alu_result = alu_a | s_bb;
            default: alu_result = s_sum[3:0];
        endcase
        alu_cout     = s_sum[4];
        alu_set      = s_sum[3];
        alu_overflow = (alu_a[3] == s_bb[3]) && (s_sum[3] != alu_a[3]);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Whole-word reference: extended-precision signed/unsigned sums.
    function automatic void model(input logic [15:0] ma,
                                  input logic [15:0] mb,
                                  input logic [2:0] mo,
                                  output logic [15:0] r,
                                  output logic c,
                                  output logic v);
        logic [15:0] bb;
        logic [16:0] s;
        logic [17:0] t;
        bb = mo[2] ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, bb} + 17'(mo[2]);
        t  = {{2{ma[15]}}, ma} + {{2{bb[15]}}, bb} + 18'(mo[2]);
        case (mo[1:0])
            2'b00:   r = ma & bb;
            2'b01:   r = ma | bb;
            2'b10:   r = s[15:0];
            default: r = {15'b0, t[17]};
        endcase
        c = mo[1] ? s[16] : 1'b0;
        v = mo[1] ? (t[16] ^ t[15]) : 1'b0;
    endfunction

    // Cycle model: cnt 0 idle, 1..4 nibble passes, 5 done cycle.
    int          cnt = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;
    logic [2:0]  m_op = '0;
    logic [15:0] e_res = '0;
    logic        e_c = 1'b0;
    logic        e_v = 1'b0;

    always @(posedge clk) begin
        logic [15:0] r;
        logic        c;
        logic        v;
        if (!rst_n) begin
            cnt   <= 0;
            e_res <= '0;
            e_c   <= 1'b0;
            e_v   <= 1'b0;
            m_a   <= '0;
            m_b   <= '0;
            m_op  <= '0;
        end else if (cnt == 0) begin
            if (start) begin
                cnt  <= 1;
                m_a  <= a;
                m_b  <= b;
                m_op <= op;
                model(a, b, op, r, c, v);
                e_res <= r;
                e_c   <= c;
                e_v   <= v;
            end
        end else begin
            cnt <= (cnt == 5) ? 0 : cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, cnt != 0);
        chk("done", done, cnt == 5);
        if (cnt == 0 || cnt == 5) begin
            chk("result", result, e_res);
            chk("cout", cout, e_c);
            chk("overflow", overflow, e_v);
            chk("zero", zero, e_res == 16'h0);
        end
        if (cnt >= 1 && cnt <= 4) begin
            chk("alu_a", alu_a, m_a[4*(cnt-1) +: 4]);
            chk("alu_b", alu_b, m_b[4*(cnt-1) +: 4]);
            chk("alu_op", alu_op, m_op);
            if (cnt == 1) chk("alu_cin0", alu_cin, m_op[2]);
        end
    end

    task automatic run_op(input string nm, input logic [15:0] ta,
                          input logic [15:0] tbv, input logic [2:0] top,
                          input logic [15:0] er, input logic ec,
                          input logic ev);
        int lat;
        @(negedge clk);
        a = ta;
        b = tbv;
        op = top;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, lat, 5);
        chk({nm, " result"}, result, er);
        chk({nm, " cout"}, cout, ec);
        chk({nm, " overflow"}, overflow, ev);
        chk({nm, " zero"}, zero, er == 16'h0);
    endtask

    initial begin
        int ndone;
        int first;
        int gap;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst result", result, 0);
        chk("rst zero", zero, 1);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_cin", alu_cin, 0);
        rst_n = 1'b1;

        run_op("add", 16'h0FFF, 16'h0001, OP_ADD, 16'h1000, 0, 0);
        run_op("sub", 16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 1, 1);
        run_op("subz", 16'h1234, 16'h1234, OP_SUB, 16'h0000, 1, 0);
        run_op("slt1", 16'h8000, 16'h0001, OP_SLT, 16'h0001, 1, 1);
        run_op("slt2", 16'h0005, 16'h0003, OP_SLT, 16'h0000, 1, 0);
        run_op("slt3", 16'h7FFF, 16'hFFFF, OP_SLT, 16'h0000, 0, 1);
        run_op("and", 16'hF0F0, 16'h3C3C, OP_AND, 16'h3030, 0, 0);
        run_op("or", 16'hF0F0, 16'h3C3C, OP_OR, 16'hFCFC, 0, 0);
        run_op("andn", 16'hF0F0, 16'h3C3C, 3'b100, 16'hC0C0, 0, 0);
        run_op("add_wrap", 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1, 0);

        // Start held high: one accept per six cycles.
        @(negedge clk);
        a = 16'h0011;
        b = 16'h0022;
        op = OP_ADD;
        start = 1'b1;
        ndone = 0;
        first = -1;
        gap = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0) first = i;
                else if (gap == 0) gap = i - first;
            end
        end
        start = 1'b0;
        chk("held dones", ndone, 3);
        chk("held gap", gap, 6);
        repeat (8) @(negedge clk);

        // Start pulses during RUN and DONE give no extra completion.
        @(negedge clk);
        a = 16'h0100;
        b = 16'h0200;
        op = OP_ADD;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cnt != 0) @(negedge clk);
        chk("pulse result", result, 16'h0300);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("pulse extra done", ndone, 0);

        // Reset during nibble 2 aborts the operation.
        @(negedge clk);
        a = 16'h5555;
        b = 16'h1111;
        op = OP_ADD;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", busy, 0);
        chk("abort result", result, 0);
        chk("abort zero", zero, 1);
        chk("abort done", done, 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", ndone, 0);
        run_op("post_rst", 16'h1234, 16'h0F0F, OP_SUB, 16'h0325, 1, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
